// File: rtl/gba_cart_pkg.sv
// gba_cart_pkg
//   Shared definitions for the GBA cartridge ROM read path: bus widths,
//   the read sequencer state encoding, idle levels of the cartridge pins
//   and small helpers that decode which pins a state drives.
//   No ports (package).
package gba_cart_pkg;

    localparam int ADDR_W  = 24;
    localparam int DATA_W  = 16;
    localparam int TIMER_W = 8;
    // Beat counter must hold 256 (req_len == 0).
    localparam int CNT_W   = 9;

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        LATCH,
        TURN,
        RD_LO,
        RD_HI,
        END
    } state_e;

    localparam logic PIN_NCS_IDLE    = 1'b1;
    localparam logic PIN_NRD_IDLE    = 1'b1;
    localparam logic PIN_EN_IDLE     = 1'b0;
    localparam logic CART_CLK_LEVEL  = 1'b0;
    localparam logic CART_NWR_LEVEL  = 1'b1;
    localparam logic CART_NCS2_LEVEL = 1'b1;

    // Address is on the AD bus while it is being set up and latched.
    function automatic logic drives_address(input state_e s);
        return (s == ADDR) || (s == LATCH);
    endfunction

    // Chip select stays low from the latch until the burst segment ends.
    function automatic logic cs_active(input state_e s);
        return (s == LATCH) || (s == TURN) || (s == RD_LO) || (s == RD_HI);
    endfunction

endpackage

// File: rtl/gba_phase_timer.sv
// gba_phase_timer
//   Loadable down-counter timing one bus phase. Loading value N makes
//   done_o rise in the N-th cycle of the phase (the cycle after the load
//   edge counts as the first). done_o stays high until the next load.
// Ports:
//   clk      in   system clock
//   rst_n    in   asynchronous active-low reset
//   load_i   in   start a new phase
//   value_i  in   phase length in cycles (>=1)
//   done_o   out  current cycle is the last (or later) cycle of the phase
module gba_phase_timer
    import gba_cart_pkg::*;
#(
    parameter int W = TIMER_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load_i,
    input  logic [W-1:0] value_i,
    output logic         done_o
);

    logic [W-1:0] count_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else if (load_i) begin
            count_q <= value_i - W'(1);
        end else if (count_q != '0) begin
            count_q <= count_q - W'(1);
        end
    end

    assign done_o = (count_q == '0);

endmodule

// File: rtl/gba_rom_reader.sv
// gba_rom_reader
//   Bus-cycle sequencer for GBA cartridge ROM bursts. Latches the start
//   address on the nCS fall, then pulses nRD once per halfword and hands
//   each captured halfword out on a valid/ready stream. Bursts crossing a
//   64K-halfword boundary are split with a fresh address phase because the
//   cartridge's internal counter does not carry into the upper address.
// Ports:
//   clk, rst_n                       clock, asynchronous active-low reset
//   req_valid/req_ready/req_addr/req_len   burst request (len 0 = 256)
//   rsp_valid/rsp_ready/rsp_data/rsp_last  halfword response stream
//   busy                             sequencer not idle
//   add_dat_en/add_dat               AD bus drive enable and value
//   data_read                        AD[15:0] read back by the pin block
//   cart_clk/cart_nCS/cart_nRD/cart_nWR/cart_nCS2  cartridge control pins
module gba_rom_reader
    import gba_cart_pkg::*;
#(
    parameter int unsigned T_SETUP = 2,
    parameter int unsigned T_RD_LO = 3,
    parameter int unsigned T_RD_HI = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [7:0]        req_len,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_last,
    output logic              busy,
    output logic              add_dat_en,
    output logic [ADDR_W-1:0] add_dat,
    input  logic [DATA_W-1:0] data_read,
    output logic              cart_clk,
    output logic              cart_nCS,
    output logic              cart_nRD,
    output logic              cart_nWR,
    output logic              cart_nCS2
);

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   cur_addr_q, cur_addr_d;
    logic [CNT_W-1:0]    remaining_q, remaining_d;
    logic                rsp_valid_q, rsp_valid_d;
    logic                rsp_last_q, rsp_last_d;
    logic [DATA_W-1:0]   rsp_data_q, rsp_data_d;
    logic                acc_q, acc_d;
    logic                ncs_q, ncs_d;
    logic                nrd_q, nrd_d;
    logic                en_q, en_d;
    logic [ADDR_W-1:0]   ad_q, ad_d;

    logic                tmr_load;
    logic [TIMER_W-1:0]  tmr_value;
    logic                tmr_done;
    logic                rsp_fire;

    assign rsp_fire = rsp_valid_q & rsp_ready;

    gba_phase_timer #(.W(TIMER_W)) u_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .load_i  (tmr_load),
        .value_i (tmr_value),
        .done_o  (tmr_done)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cur_addr_q  <= '0;
            remaining_q <= '0;
            rsp_valid_q <= 1'b0;
            rsp_last_q  <= 1'b0;
            rsp_data_q  <= '0;
            acc_q       <= 1'b0;
            ncs_q       <= PIN_NCS_IDLE;
            nrd_q       <= PIN_NRD_IDLE;
            en_q        <= PIN_EN_IDLE;
            ad_q        <= '0;
        end else begin
            state_q     <= state_d;
            cur_addr_q  <= cur_addr_d;
            remaining_q <= remaining_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_last_q  <= rsp_last_d;
            rsp_data_q  <= rsp_data_d;
            acc_q       <= acc_d;
            ncs_q       <= ncs_d;
            nrd_q       <= nrd_d;
            en_q        <= en_d;
            ad_q        <= ad_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cur_addr_d  = cur_addr_q;
        remaining_d = remaining_q;
        rsp_valid_d = rsp_valid_q;
        rsp_last_d  = rsp_last_q;
        rsp_data_d  = rsp_data_q;
        acc_d       = acc_q;
        tmr_load    = 1'b0;
        tmr_value   = '0;

        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    cur_addr_d  = req_addr;
                    remaining_d = (req_len == 8'd0) ? 9'd256 : {1'b0, req_len};
                    state_d     = ADDR;
                    tmr_load    = 1'b1;
                    tmr_value   = TIMER_W'(T_SETUP);
                end
            end
            ADDR: begin
                if (tmr_done) begin
                    state_d = LATCH;
                end
            end
            LATCH: begin
                state_d = TURN;
            end
            TURN: begin
                state_d   = RD_LO;
                tmr_load  = 1'b1;
                tmr_value = TIMER_W'(T_RD_LO);
            end
            RD_LO: begin
                if (tmr_done) begin
                    // rsp_last is judged on the count before this beat is consumed.
                    rsp_data_d  = data_read;
                    rsp_valid_d = 1'b1;
                    rsp_last_d  = (remaining_q == 9'd1);
                    remaining_d = remaining_q - 9'd1;
                    cur_addr_d  = cur_addr_q + 24'd1;
                    acc_d       = 1'b0;
                    state_d     = RD_HI;
                    tmr_load    = 1'b1;
                    tmr_value   = TIMER_W'(T_RD_HI);
                end
            end
            RD_HI: begin
                if (rsp_fire) begin
                    rsp_valid_d = 1'b0;
                    rsp_last_d  = 1'b0;
                    acc_d       = 1'b1;
                end
                if (tmr_done && (acc_q || rsp_fire)) begin
                    if ((remaining_q == '0) || (cur_addr_q[15:0] == 16'h0000)) begin
                        state_d = END;
                    end else begin
                        state_d   = RD_LO;
                        tmr_load  = 1'b1;
                        tmr_value = TIMER_W'(T_RD_LO);
                    end
                end
            end
            END: begin
                if (remaining_q != '0) begin
                    state_d   = ADDR;
                    tmr_load  = 1'b1;
                    tmr_value = TIMER_W'(T_SETUP);
                end else begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Pins are decoded from the next state so the registered pin levels
    // line up with the state they belong to.
    always_comb begin
        ncs_d = cs_active(state_d) ? 1'b0 : PIN_NCS_IDLE;
        nrd_d = (state_d == RD_LO) ? 1'b0 : PIN_NRD_IDLE;
        en_d  = drives_address(state_d);
        ad_d  = en_d ? cur_addr_d : '0;
    end

    assign req_ready  = (state_q == IDLE);
    assign busy       = (state_q != IDLE);
    assign rsp_valid  = rsp_valid_q;
    assign rsp_last   = rsp_last_q;
    assign rsp_data   = rsp_data_q;
    assign add_dat_en = en_q;
    assign add_dat    = ad_q;
    assign cart_nCS   = ncs_q;
    assign cart_nRD   = nrd_q;
    assign cart_clk   = CART_CLK_LEVEL;
    assign cart_nWR   = CART_NWR_LEVEL;
    assign cart_nCS2  = CART_NCS2_LEVEL;

endmodule

// File: tb/tb_gba_rom_reader.sv
// tb_gba_rom_reader
//   Directed bench for gba_rom_reader. A small cartridge model latches the
//   address while nCS is low with the AD bus driven and advances it on each
//   nRD rising edge; it returns the low 16 address bits (or 0xBEEF in fixed
//   mode). Outputs are sampled on the falling clock edge.
module tb_gba_rom_reader;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [23:0] req_addr;
    logic [7:0]  req_len;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [15:0] rsp_data;
    logic        rsp_last;
    logic        busy;
    logic        add_dat_en;
    logic [23:0] add_dat;
    logic [15:0] data_read;
    logic        cart_clk;
    logic        cart_nCS;
    logic        cart_nRD;
    logic        cart_nWR;
    logic        cart_nCS2;

    int checks   = 0;
    int failures = 0;

    logic [23:0] mAddr     = '0;
    logic        mLastNrd  = 1'b1;
    logic        fixedData = 1'b0;

    int          beatsGot, dataErr, lastErr, pulses, adPhases;
    int          stallViol, stallSeen, dropViol, endCycles, overlapViol;
    logic        burstDone;
    logic [23:0] adVal [0:7];
    int          fallCyc [0:299];

    gba_rom_reader dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_addr   (req_addr),
        .req_len    (req_len),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_data   (rsp_data),
        .rsp_last   (rsp_last),
        .busy       (busy),
        .add_dat_en (add_dat_en),
        .add_dat    (add_dat),
        .data_read  (data_read),
        .cart_clk   (cart_clk),
        .cart_nCS   (cart_nCS),
        .cart_nRD   (cart_nRD),
        .cart_nWR   (cart_nWR),
        .cart_nCS2  (cart_nCS2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (!cart_nCS && add_dat_en) begin
            mAddr <= add_dat;
        end else if (cart_nRD && !mLastNrd) begin
            mAddr <= mAddr + 24'd1;
        end
        mLastNrd <= cart_nRD;
    end

    assign data_read = fixedData ? 16'hBEEF : mAddr[15:0];

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    // Called at a falling edge while idle; returns at the falling edge of
    // the first cycle after the request was accepted.
    task automatic applyStimulus(input logic [23:0] addr, input logic [7:0] len);
        req_addr  = addr;
        req_len   = len;
        req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic runBurst(input logic [23:0] addr, input int len, input int stallBeat,
                            input int stallLen, input int maxCycles);
        logic        prevNrd;
        logic        prevEn;
        logic        prevHs;
        logic [15:0] heldData;
        logic [23:0] expAddr;
        logic [31:0] lenBits;
        beatsGot = 0; dataErr = 0; lastErr = 0; pulses = 0; adPhases = 0;
        stallViol = 0; stallSeen = 0; dropViol = 0; endCycles = 0; overlapViol = 0;
        prevNrd = 1'b1; prevEn = 1'b0; prevHs = 1'b0; heldData = '0;
        lenBits = len;
        applyStimulus(addr, lenBits[7:0]);
        for (int cyc = 0; cyc < maxCycles && !(beatsGot == len && !busy); cyc++) begin
            if (add_dat_en && !prevEn) begin
                if (adPhases < 8) adVal[adPhases] = add_dat;
                adPhases++;
            end
            if (!cart_nRD && prevNrd) begin
                if (pulses < 300) fallCyc[pulses] = cyc;
                pulses++;
            end
            if (add_dat_en && !cart_nRD) overlapViol++;
            if (busy && cart_nCS && !add_dat_en) endCycles++;
            if (prevHs && rsp_valid) dropViol++;
            prevHs = 1'b0;
            if (rsp_valid) begin
                if (beatsGot == stallBeat && stallSeen < stallLen) begin
                    if (stallSeen == 0) heldData = rsp_data;
                    else if (rsp_data !== heldData) stallViol++;
                    if (!cart_nRD || cart_nCS) stallViol++;
                    rsp_ready = 1'b0;
                    stallSeen++;
                end else begin
                    rsp_ready = 1'b1;
                    expAddr = addr + 24'(beatsGot);
                    if (rsp_data !== expAddr[15:0]) dataErr++;
                    if (rsp_last !== (beatsGot == len - 1)) lastErr++;
                    beatsGot++;
                    prevHs = 1'b1;
                end
            end else begin
                rsp_ready = 1'b1;
            end
            prevNrd = cart_nRD;
            prevEn  = add_dat_en;
            @(negedge clk);
        end
        burstDone = (beatsGot == len) && !busy;
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog expired observed=running expected=finished");
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        int   falls;
        logic found;
        logic prevN;

        rst_n = 1'b0; req_valid = 1'b0; req_addr = '0; req_len = '0; rsp_ready = 1'b1;

        // Reset state
        @(negedge clk);
        checkOutput("reset_pins", {cart_nCS, cart_nRD, add_dat_en, cart_clk, cart_nWR, cart_nCS2},
                    6'b110011);
        checkOutput("reset_ad", add_dat, 24'h0);
        checkOutput("reset_rsp", {rsp_valid, rsp_last, busy, req_ready}, 4'b0001);
        checkOutput("reset_data", rsp_data, 16'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Single read returning 0xBEEF
        $display("[TB] single read");
        fixedData = 1'b1;
        applyStimulus(24'h000010, 8'd1);
        checkOutput("t1_setup1", {add_dat_en, cart_nCS, req_ready, busy}, 4'b1101);
        checkOutput("t1_setup1_ad", add_dat, 24'h000010);
        @(negedge clk);
        checkOutput("t1_setup2", {add_dat_en, cart_nCS, cart_nRD}, 3'b111);
        @(negedge clk);
        checkOutput("t1_latch", {add_dat_en, cart_nCS, cart_nRD}, 3'b101);
        checkOutput("t1_latch_ad", add_dat, 24'h000010);
        @(negedge clk);
        checkOutput("t1_turn", {add_dat_en, cart_nCS, cart_nRD}, 3'b001);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checkOutput("t1_rd_lo", {cart_nRD, cart_nCS, rsp_valid, add_dat_en}, 4'b0000);
        end
        @(negedge clk);
        checkOutput("t1_rsp", {rsp_valid, rsp_last, cart_nRD, cart_nCS}, 4'b1110);
        checkOutput("t1_rsp_data", rsp_data, 16'hBEEF);
        @(negedge clk);
        checkOutput("t1_rsp_drop", {rsp_valid, cart_nCS}, 2'b00);
        @(negedge clk);
        checkOutput("t1_end", {cart_nCS, cart_nRD, add_dat_en, busy}, 4'b1101);
        @(negedge clk);
        checkOutput("t1_idle", {req_ready, busy}, 2'b10);
        fixedData = 1'b0;

        // Four-beat burst, no stall
        $display("[TB] burst of 4");
        runBurst(24'h000100, 4, -1, 0, 200);
        checkOutput("t2_done", burstDone, 1'b1);
        checkOutput("t2_data_err", dataErr, 0);
        checkOutput("t2_last_err", lastErr, 0);
        checkOutput("t2_pulses", pulses, 4);
        checkOutput("t2_addr_phases", adPhases, 1);
        checkOutput("t2_addr_val", adVal[0], 24'h000100);
        checkOutput("t2_end_cycles", endCycles, 1);
        checkOutput("t2_overlap", overlapViol, 0);
        checkOutput("t2_valid_drop", dropViol, 0);
        for (int i = 0; i < 3; i++) begin
            checkOutput("t2_period", fallCyc[i+1] - fallCyc[i], 5);
        end
        checkOutput("t2_idle", req_ready, 1'b1);

        // Three beats, consumer stalls ten cycles on beat 2
        $display("[TB] backpressure");
        runBurst(24'h000300, 3, 1, 10, 300);
        checkOutput("t3_done", burstDone, 1'b1);
        checkOutput("t3_stall_len", stallSeen, 10);
        checkOutput("t3_stall_hold", stallViol, 0);
        checkOutput("t3_data_err", dataErr, 0);
        checkOutput("t3_last_err", lastErr, 0);
        checkOutput("t3_pulses", pulses, 3);
        checkOutput("t3_valid_drop", dropViol, 0);

        // 64K-halfword boundary split
        $display("[TB] boundary split");
        runBurst(24'h00FFFE, 4, -1, 0, 300);
        checkOutput("t4_done", burstDone, 1'b1);
        checkOutput("t4_addr_phases", adPhases, 2);
        checkOutput("t4_addr0", adVal[0], 24'h00FFFE);
        checkOutput("t4_addr1", adVal[1], 24'h010000);
        checkOutput("t4_end_cycles", endCycles, 2);
        checkOutput("t4_data_err", dataErr, 0);
        checkOutput("t4_last_err", lastErr, 0);
        checkOutput("t4_pulses", pulses, 4);
        checkOutput("t4_overlap", overlapViol, 0);

        // len = 0 means 256 beats
        $display("[TB] len 0");
        runBurst(24'h000200, 256, -1, 0, 3000);
        checkOutput("t5_done", burstDone, 1'b1);
        checkOutput("t5_beats", beatsGot, 256);
        checkOutput("t5_pulses", pulses, 256);
        checkOutput("t5_last_err", lastErr, 0);
        checkOutput("t5_data_err", dataErr, 0);
        checkOutput("t5_addr_phases", adPhases, 1);

        // Reset during RD_LO of beat 2
        $display("[TB] reset mid-burst");
        applyStimulus(24'h000400, 8'd4);
        falls = 0; found = 1'b0; prevN = 1'b1;
        for (int c = 0; c < 100 && !found; c++) begin
            if (!cart_nRD && prevN) falls++;
            if (falls == 2) begin
                found = 1'b1;
            end else begin
                prevN = cart_nRD;
                @(negedge clk);
            end
        end
        checkOutput("t6_reached_beat2", found, 1'b1);
        checkOutput("t6_pre_reset", {cart_nRD, cart_nCS, busy}, 3'b001);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("t6_async_reset", {cart_nCS, cart_nRD, rsp_valid, add_dat_en, busy, req_ready},
                    6'b110001);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("t6_idle", {req_ready, busy}, 2'b10);
        runBurst(24'h000020, 1, -1, 0, 100);
        checkOutput("t6_new_done", burstDone, 1'b1);
        checkOutput("t6_new_data", dataErr, 0);
        checkOutput("t6_new_last", lastErr, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
